// File: rtl/bus_pkg.sv
// Shared definitions for the bus wait-state sequencer: state encodings,
// default widths and a lowest-set-bit priority encoder.
package bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_T1   = 2'd1,
      ST_TW   = 2'd2,
      ST_T2   = 2'd3
   } bus_state_e;

   localparam int BUS_WS_W    = 4;
   localparam int BUS_TIMEOUT = 255;
   localparam int BUS_TO_W    = $clog2(BUS_TIMEOUT + 1);
   localparam int BUS_MAX_TGT = 8;

   // Scans downwards so the lowest set bit is the last one written.
   function automatic logic [2:0] lsb_index(input logic [BUS_MAX_TGT-1:0] v);
      lsb_index = 3'd0;
      for (int i = BUS_MAX_TGT - 1; i >= 0; i--)
         if (v[i]) lsb_index = 3'(i);
   endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
module bus_wait_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             _rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/bus_wait_sequencer.sv
// 386-style local bus cycle sequencer: T1/TW/T2 with per-target wait states.
// Optional BUS_TIMEOUT_EN forces completion when _dev_rdy never arrives.
module bus_wait_sequencer
   import bus_pkg::*;
#(
   parameter int NTARGETS = 4,
   parameter int WS_W     = BUS_WS_W,
   parameter int TIMEOUT  = BUS_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     _rst,
   input  logic                     _ads,
   input  logic                     w_r,
   input  logic [NTARGETS-1:0]      sel,
   input  logic [NTARGETS*WS_W-1:0] ws_cfg,
   input  logic                     _dev_rdy,
   output logic                     _ready,
   output logic                     bce,
   output logic                     oe,
   output logic                     dir,
   output logic [NTARGETS-1:0]      cs,
   output logic                     busy,
   output logic                     err
);

   bus_state_e state, nxt;

   logic                   start;
   logic [BUS_MAX_TGT-1:0] sel_ext;
   logic [2:0]             sel_idx;
   logic                   sel_any;
   logic [WS_W-1:0]        w_sel, w_q, w_load;
   logic [NTARGETS-1:0]    cs_sel;
   logic                   tgt_vld;
   logic                   wait_zero;
   logic                   force_t2;
   logic                   busy_q;

   assign start   = !_ads && (state == ST_IDLE || state == ST_T2);
   assign sel_ext = BUS_MAX_TGT'(sel);
   assign sel_idx = lsb_index(sel_ext);
   assign sel_any = |sel;
   assign w_sel   = sel_any ? ws_cfg[int'(sel_idx)*WS_W +: WS_W] : '0;
   assign tgt_vld = |cs;
   assign w_load  = (w_q == '0) ? '0 : w_q - 1'b1;

   always_comb begin
      cs_sel = '0;
      for (int i = 0; i < NTARGETS; i++)
         if (sel_any && sel_idx == 3'(i)) cs_sel[i] = 1'b1;
   end

   bus_wait_counter #(.WIDTH(WS_W)) u_wait (
      .clk      (clk),
      ._rst     (_rst),
      .load     (state == ST_T1),
      .load_val (w_load),
      .dec      (state == ST_TW),
      .zero     (wait_zero)
   );

`ifdef BUS_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic tmo_zero, tmo_wait;

   // Counts only TW cycles spent purely waiting on the device.
   assign tmo_wait = (state == ST_TW) && wait_zero && _dev_rdy;
   assign force_t2 = tmo_wait && tmo_zero;

   bus_wait_counter #(.WIDTH(TO_W)) u_tmo (
      .clk      (clk),
      ._rst     (_rst),
      .load     (state == ST_T1),
      .load_val (TO_W'(TIMEOUT - 1)),
      .dec      (tmo_wait),
      .zero     (tmo_zero)
   );

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst)
         err <= 1'b0;
      else if (start)
         err <= 1'b0;
      else if (force_t2)
         err <= 1'b1;
   end
`else
   assign force_t2 = 1'b0;
   assign err      = 1'b0;
`endif

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: if (start) nxt = ST_T1;
         // Unclaimed cycles have W=0 and must not wait on a device.
         ST_T1:   nxt = (w_q == '0 && (!_dev_rdy || !tgt_vld)) ? ST_T2 : ST_TW;
         ST_TW:   if (wait_zero && (!_dev_rdy || force_t2)) nxt = ST_T2;
         ST_T2:   nxt = start ? ST_T1 : ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         state  <= ST_IDLE;
         _ready <= 1'b1;
         busy_q <= 1'b0;
         oe     <= 1'b0;
         dir    <= 1'b0;
         cs     <= '0;
         w_q    <= '0;
      end else begin
         state  <= nxt;
         _ready <= (nxt != ST_T2);
         busy_q <= (nxt != ST_IDLE);
         // T2 is never entered on a start edge, so cs is already current.
         oe     <= (nxt == ST_T2) && tgt_vld && !force_t2;
         if (start) begin
            dir <= w_r;
            cs  <= cs_sel;
            w_q <= w_sel;
         end else if (nxt == ST_IDLE) begin
            cs  <= '0;
         end
      end
   end

   assign bce  = busy_q;
   assign busy = busy_q;

endmodule
